// File: rtl/ccff_loader.sv
// ccff_loader -- streams a bitstream into NUM_CHAINS parallel configuration
// flip-flop chains, CHAIN_LEN bits deep, one frame (one bit per chain) per
// accepted handshake.
//
// Optional feature: define CCFF_READBACK_CHECK_EN to add a READBACK pass.
// The upstream re-sends the same bitstream, and each bit leaving a chain
// tail is compared with the bit being shifted in. Any difference sets a
// sticky error flag. With the macro undefined, SHIFT completes straight
// into DONE and error is tied low.
//
// Ports:
//   prog_clk, prog_reset   clock, asynchronous active-low reset
//   start, abort           load control (abort wins, returns to IDLE)
//   bs_valid/bs_ready      frame handshake, bs_data = one bit per chain
//   ccff_head, shift_en    registered chain head data and shift strobe
//   ccff_tail              chain tail data (used only for readback)
//   config_enable, busy    high while loading (SHIFT / READBACK)
//   done                   level, high in DONE
//   error                  sticky readback mismatch
module ccff_loader #(
  parameter int NUM_CHAINS = 8,
  parameter int CHAIN_LEN  = 1024
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  input  logic [NUM_CHAINS-1:0] bs_data,
  output logic [NUM_CHAINS-1:0] ccff_head,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  shift_en,
  output logic                  config_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(CHAIN_LEN - 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SHIFT    = 2'd1;
  localparam logic [1:0] S_READBACK = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt;
  logic             loading;
  logic             hs;
  logic             last_hs;
  logic             start_load;

  assign loading       = (state == S_SHIFT) || (state == S_READBACK);
  // abort masks ready so a frame presented alongside it is never taken
  assign bs_ready      = loading && !abort;
  assign busy          = loading;
  assign config_enable = loading;
  assign done          = (state == S_DONE);

  assign hs         = bs_valid && bs_ready;
  assign last_hs    = hs && (bit_cnt == LAST_M1);
  assign start_load = start && !abort && ((state == S_IDLE) || (state == S_DONE));

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:     if (start) state_nxt = S_SHIFT;
`ifdef CCFF_READBACK_CHECK_EN
        S_SHIFT:    if (last_hs) state_nxt = S_READBACK;
`else
        S_SHIFT:    if (last_hs) state_nxt = S_DONE;
`endif
        S_READBACK: if (last_hs) state_nxt = S_DONE;
        S_DONE:     if (start) state_nxt = S_SHIFT;
        default:    state_nxt = S_IDLE;
      endcase
    end
  end

  // The final shift_en pulse is registered on the same edge that enters
  // DONE, so the fabric takes its last bit on the first DONE edge.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      ccff_head <= '0;
      shift_en  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift_en <= hs;
      if (hs) ccff_head <= bs_data;
      if (abort || start_load)
        bit_cnt <= '0;
      else if (hs)
        bit_cnt <= last_hs ? '0 : bit_cnt + 1'b1;
    end
  end

`ifdef CCFF_READBACK_CHECK_EN
  logic rb_shift;   // the pending shift_en pulse carries a readback frame
  logic error_q;

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      rb_shift <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      rb_shift <= hs && (state == S_READBACK);
      // Last readback compare lands in DONE, so gate on the pulse, not state.
      if (start_load)
        error_q <= 1'b0;
      else if (!abort && shift_en && rb_shift && |(ccff_head ^ ccff_tail))
        error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_tail;
  assign unused_tail = ^ccff_tail;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// tb_ccff_loader -- directed bench for ccff_loader with CHAIN_LEN=4,
// NUM_CHAINS=8 and a behavioural chain model on ccff_head/ccff_tail.
// Works with or without CCFF_READBACK_CHECK_EN; in the readback build
// every load sends its four frames twice.
module tb_ccff_loader;
  localparam int NC = 8;
  localparam int CL = 4;
`ifdef CCFF_READBACK_CHECK_EN
  localparam int NP = 2 * CL;
`else
  localparam int NP = CL;
`endif

  logic          prog_clk = 1'b0;
  logic          prog_reset;
  logic          start, abort, bs_valid, bs_ready;
  logic [NC-1:0] bs_data, ccff_head, ccff_tail;
  logic          shift_en, config_enable, busy, done, error;

  ccff_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .abort(abort),
    .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_data(bs_data),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .shift_en(shift_en),
    .config_enable(config_enable), .busy(busy), .done(done), .error(error)
  );

  always #5 prog_clk = ~prog_clk;

  // chain model: bit 0 nearest the head, bit CL-1 is the tail
  logic [NC-1:0][CL-1:0] chain = '0;
  logic [7:0]            heads [16];
  int                    pulses = 0;
  logic                  clr_cnt = 1'b0;
  logic                  flip_req = 1'b0;

  always @(posedge prog_clk) begin
    if (shift_en) begin
      for (int i = 0; i < NC; i++) chain[i] <= {chain[i][CL-2:0], ccff_head[i]};
    end else if (flip_req) begin
      chain[3][0] <= ~chain[3][0];
    end
    if (clr_cnt) pulses <= 0;
    else if (shift_en) begin
      if (pulses < 16) heads[pulses] <= ccff_head;
      pulses <= pulses + 1;
    end
  end

  always_comb begin
    ccff_tail = '0;
    for (int i = 0; i < NC; i++) ccff_tail[i] = chain[i][CL-1];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    bs_valid = 1'b1;
    bs_data  = d;
    while (!bs_ready && n < 20) begin
      @(negedge prog_clk);
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
    @(negedge prog_clk);
    bs_valid = 1'b0;
  endtask

  task automatic do_start();
    start   = 1'b1;
    clr_cnt = 1'b1;
    @(negedge prog_clk);
    start   = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, b, c, d);
    send(a); send(b); send(c); send(d);
`ifdef CCFF_READBACK_CHECK_EN
    send(a); send(b); send(c); send(d);
`endif
    repeat (2) @(negedge prog_clk);
  endtask

  task automatic check_load(input string tag, input logic [7:0] a, b, c, d,
                            input logic [31:0] exp_chain);
    chk({tag, "_pulses"}, 32'(pulses), 32'(NP));
    chk({tag, "_heads"}, {heads[0], heads[1], heads[2], heads[3]}, {a, b, c, d});
    chk({tag, "_chain"}, chain, exp_chain);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_cfg_en"}, 32'(config_enable), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(bs_ready), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  // bit i of every frame lands in chain i; first frame ends at the tail
  localparam logic [31:0] CHAIN_1248 = 32'h0000_1248;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prog_reset = 1'b0;
    start = 1'b0; abort = 1'b0; bs_valid = 1'b0; bs_data = '0;
    #1;
    chk("rst_outs", {ccff_head, 5'(0), shift_en, config_enable, bs_ready, busy, done, error, 17'(0)}, 32'd0);
    repeat (2) @(negedge prog_clk);
    prog_reset = 1'b1;
    @(negedge prog_clk);
    chk("idle_ready", 32'(bs_ready), 32'd0);

    // 1: back-to-back load
    do_start();
    chk("shift_busy", {29'(0), busy, config_enable, bs_ready}, 32'd7);
    load(8'h01, 8'h02, 8'h04, 8'h08);
    check_load("b2b", 8'h01, 8'h02, 8'h04, 8'h08, CHAIN_1248);
    // frames offered in DONE must be ignored
    bs_valid = 1'b1; bs_data = 8'hFF;
    repeat (2) @(negedge prog_clk);
    bs_valid = 1'b0;
    @(negedge prog_clk);
    chk("done_no_shift", 32'(pulses), 32'(NP));

    // 2: three idle cycles between frames 2 and 3
    do_start();
    send(8'h01); send(8'h02);
    repeat (3) @(negedge prog_clk);
    chk("gap_pulses", 32'(pulses), 32'd2);
    chk("gap_noshift", 32'(shift_en), 32'd0);
    send(8'h04); send(8'h08);
`ifdef CCFF_READBACK_CHECK_EN
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
`endif
    repeat (2) @(negedge prog_clk);
    check_load("gap", 8'h01, 8'h02, 8'h04, 8'h08, CHAIN_1248);

    // 3: abort alongside frame 3
    do_start();
    send(8'h10); send(8'h20);
    bs_valid = 1'b1; bs_data = 8'h40; abort = 1'b1;
    #1;
    chk("abort_ready", 32'(bs_ready), 32'd0);
    @(negedge prog_clk);
    abort = 1'b0; bs_valid = 1'b0;
    chk("abort_state", {28'(0), busy, done, shift_en, bs_ready}, 32'd0);
    chk("abort_head", 32'(ccff_head), 32'h20);
    @(negedge prog_clk);
    chk("abort_pulses", 32'(pulses), 32'd2);
    do_start();
    load(8'h01, 8'h02, 8'h04, 8'h08);
    check_load("reload", 8'h01, 8'h02, 8'h04, 8'h08, CHAIN_1248);

    // 4: reset mid-load
    do_start();
    send(8'h80); send(8'h40);
    prog_reset = 1'b0;
    #1;
    chk("mid_rst", {ccff_head, 5'(0), shift_en, config_enable, bs_ready, busy, done, error, 17'(0)}, 32'd0);
    repeat (2) @(negedge prog_clk);
    prog_reset = 1'b1;
    repeat (2) @(negedge prog_clk);
    chk("post_rst_idle", {30'(0), busy, done}, 32'd0);
    do_start();
    load(8'h01, 8'h02, 8'h04, 8'h08);
    check_load("post_rst", 8'h01, 8'h02, 8'h04, 8'h08, CHAIN_1248);

`ifdef CCFF_READBACK_CHECK_EN
    // 5: readback clean, then with chain 3 bit 0 corrupted before readback
    do_start();
    load(8'hA5, 8'h5A, 8'hFF, 8'h00);
    chk("rb_pulses", 32'(pulses), 32'd8);
    chk("rb_clean", {30'(0), error, done}, 32'd1);
    do_start();
    send(8'hA5); send(8'h5A); send(8'hFF); send(8'h00);
    @(negedge prog_clk);
    flip_req = 1'b1;
    @(negedge prog_clk);
    flip_req = 1'b0;
    chk("rb_pre_err", 32'(error), 32'd0);
    send(8'hA5); send(8'h5A); send(8'hFF); send(8'h00);
    repeat (2) @(negedge prog_clk);
    chk("rb_bad_pulses", 32'(pulses), 32'd8);
    chk("rb_bad", {30'(0), error, done}, 32'd3);
    do_start();
    chk("rb_err_clr", 32'(error), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_CHAINS, 8, number of parallel configuration chains.
- CHAIN_LEN, 1024, flip-flops per chain (>=2).
REQ-002 Ports SHALL be, one per line:
- prog_clk  input  1  programming clock; all state on rising edge.
- prog_reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a load; sampled in IDLE and DONE only.
- abort  input  1  synchronous abort; any state -> IDLE.
- bs_valid  input  1  bitstream frame valid.
- bs_ready  output  1  frame accepted when bs_valid && bs_ready.
- bs_data  input  NUM_CHAINS  one bit per chain; bit i feeds chain i.
- ccff_head  output  NUM_CHAINS  registered serial data into each chain head.
- ccff_tail  input  NUM_CHAINS  serial data from each chain tail.
- shift_en  output  1  registered; fabric chains shift on the prog_clk edge where it is high.
- config_enable  output  1  fabric configuration enable.
- busy  output  1  high in SHIFT or READBACK.
- done  output  1  level, high in DONE.
- error  output  1  sticky readback mismatch flag.
REQ-003 There SHALL be one clock (prog_clk); reset SHALL be asynchronous and active-low (prog_reset).

Function
REQ-004 FSM states SHALL be IDLE, SHIFT, READBACK, DONE.
REQ-005 IDLE -> SHIFT on start=1: clear bit_cnt and error.
REQ-006 bs_ready SHALL be 1 only in SHIFT and READBACK. It is a combinational function of state.
REQ-007 Each handshake SHALL register bs_data into ccff_head and set shift_en=1 the next cycle. Otherwise shift_en=0 and ccff_head holds.
REQ-008 bs_valid=0 SHALL stall with no shift. Gaps of any length SHALL be tolerated.
REQ-009 bit_cnt SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and increment per handshake.
REQ-010 When the handshake bringing bit_cnt to CHAIN_LEN occurs, the FSM SHALL leave SHIFT. bit_cnt resets to 0 on that transition. No further frame is accepted that cycle.
REQ-011 DONE SHALL be entered only after the final shift_en pulse has been issued.
REQ-012 config_enable SHALL be 1 in SHIFT and READBACK and 0 in IDLE and DONE.
REQ-013 In DONE, start=1 SHALL restart at SHIFT (same as REQ-005). start in SHIFT or READBACK SHALL be ignored.
REQ-014 abort=1 SHALL win over every other event in the same cycle. The next state is IDLE. shift_en and bs_ready are 0 the following cycle. ccff_head holds and error holds.
REQ-015 A frame presented in the same cycle as abort SHALL NOT be accepted (bs_ready=0 when abort=1).

Reset
REQ-016 While prog_reset=0, the following SHALL be forced immediately, without a clock:
- state=IDLE
- bit_cnt=0
- ccff_head=0
- shift_en=0
- config_enable=0
- bs_ready=0
- busy=0
- done=0
- error=0
REQ-017 Reset asserted mid-load SHALL abandon the load. After release, the block SHALL wait in IDLE for start.

Configuration
REQ-018 Macro CCFF_READBACK_CHECK_EN SHALL control readback verification.
REQ-019 Defined: SHIFT completion goes to READBACK, where the upstream re-sends the identical bitstream.
- Each READBACK handshake drives ccff_head as in SHIFT.
- On each cycle with shift_en=1, ccff_tail SHALL be compared to the ccff_head value being shifted.
- Any bit differing SHALL set error, which stays set until the next start or reset.
- After CHAIN_LEN READBACK frames, the FSM goes to DONE. Total shifts = 2*CHAIN_LEN.
REQ-020 Undefined: SHIFT completion goes directly to DONE. READBACK is unreachable. error is tied to 0. No comparison logic is synthesized.

Verification
REQ-021 Benches SHALL use CHAIN_LEN=4 and NUM_CHAINS=8 with a behavioural shift-register chain model. They SHALL cover:
- Reset then start, frames 0x01,0x02,0x04,0x08 back-to-back -> exactly 4 shift_en pulses; ccff_head sequence 0x01,0x02,0x04,0x08; model holds those values; done=1; config_enable=0.
- Same load with bs_valid low for 3 cycles between frames 2 and 3 -> still 4 pulses, no extra shift, same final contents.
- abort asserted with frame 3 valid -> frame 3 not accepted; IDLE next cycle; busy=0; done=0; next start reloads from bit_cnt=0.
- prog_reset low after 2 frames -> all outputs 0 asynchronously; after release, start plus 4 frames completes normally.
- With CCFF_READBACK_CHECK_EN: load 0xA5,0x5A,0xFF,0x00 twice -> 8 pulses, error=0, done=1. Force model chain 3 bit 0 inverted before readback -> error=1 at DONE.
- Without CCFF_READBACK_CHECK_EN: after 4 frames go to DONE; error=0; bs_ready=0 in DONE.
